// File: rtl/dm_arbiter.sv
// Round-robin two-master arbiter for the data memory: latches one request, does a same-cycle
// read-modify-write for byte-enabled stores, and returns a registered ack/err/rdata one cycle later.
// Latency: grant at the edge after req, memory access at the next edge, ack in the following cycle.
// Backpressure: a master holds req until its ack; inputs are ignored while busy.
module dm_arbiter #(
    parameter int ADDR_W      = 14,
    parameter int DEPTH_BYTES = 12288
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [3:0]        m0_be,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [3:0]        m1_be,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [31:0]       m1_rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout,
    output logic              busy,
    output logic              gnt_id
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    localparam logic [31:0] LAST_WORD = 32'(DEPTH_BYTES - 4);

    state_t            st;
    logic              r_we;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              last;
    logic              pick;
    logic              illegal;

    // On a tie the master that was not served last wins.
    assign pick    = (m0_req && m1_req) ? ~last : m1_req;
    assign illegal = (r_addr[1:0] != 2'b00) || (32'(r_addr) > LAST_WORD);

    assign dm_addr = r_addr;
    assign busy    = (st != IDLE);
    assign dm_we   = (st == ACCESS) && r_we && (r_be != 4'b0000) && !illegal && !reset;

    always_comb begin
        dm_din = dm_dout;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) dm_din[8*i +: 8] = r_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st       <= IDLE;
            r_we     <= 1'b0;
            r_be     <= 4'b0000;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            last     <= 1'b1;
            gnt_id   <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
            m0_rdata <= 32'h0;
            m1_rdata <= 32'h0;
        end else begin
            case (st)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt_id  <= pick;
                        r_we    <= pick ? m1_we    : m0_we;
                        r_be    <= pick ? m1_be    : m0_be;
                        r_addr  <= pick ? m1_addr  : m0_addr;
                        r_wdata <= pick ? m1_wdata : m0_wdata;
                        st      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Writes leave the master's rdata untouched; reads and rejects overwrite it.
                    if (gnt_id == 1'b0) begin
                        m0_ack <= 1'b1;
                        m0_err <= illegal;
                        if (illegal)    m0_rdata <= 32'h0;
                        else if (!r_we) m0_rdata <= dm_dout;
                    end else begin
                        m1_ack <= 1'b1;
                        m1_err <= illegal;
                        if (illegal)    m1_rdata <= 32'h0;
                        else if (!r_we) m1_rdata <= dm_dout;
                    end
                    last <= gnt_id;
                    st   <= ACK;
                end
                ACK: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    st     <= IDLE;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule
